fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 144 ++++++++++++++
 tb/tb_fwd_scoreboard.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: in-flight writes shift one stage per cycle after Execute; operands query them
// for bypass or stall. Optional macro FWD_SCOREBOARD_WB_BYPASS_EN also matches the registered wb port.

module fwdQuery #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int DEPTH = 2
) (
  input  logic [RA_W-1:0]             rs,
  input  logic [DEPTH-1:0]            entVld,
  input  logic [DEPTH-1:0]            entWen,
  input  logic [DEPTH-1:0]            entRdy,
  input  logic [DEPTH-1:0][RA_W-1:0]  entRd,
  input  logic [DEPTH-1:0][XLEN-1:0]  entData,
  input  logic                        wbHit,
  input  logic [RA_W-1:0]             wbRd,
  input  logic [XLEN-1:0]             wbData,
  output logic                        fwdEn,
  output logic [XLEN-1:0]             fwdData,
  output logic                        pend
);
  // Oldest candidate first so the youngest match overrides; wb sits below every entry.
  always_comb begin
    fwdEn   = 1'b0;
    fwdData = '0;
    pend    = 1'b0;
    if (wbHit && rs != '0 && wbRd == rs) begin
      fwdEn   = 1'b1;
      fwdData = wbData;
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rs != '0 && entVld[i] && entWen[i] && entRd[i] == rs) begin
        fwdEn   = entRdy[i];
        fwdData = entRdy[i] ? entData[i] : '0;
        pend    = !entRdy[i];
      end
    end
  end
endmodule

module fwd_scoreboard #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int DEPTH  = 2,
  parameter int LD_IDX = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [RA_W-1:0] issue_rd,
  input  logic            issue_wen,
  input  logic            issue_is_load,
  input  logic [XLEN-1:0] issue_result,
  input  logic            flush,
  input  logic [XLEN-1:0] ld_data,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  output logic            fwd1_en,
  output logic            fwd2_en,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
  output logic            stall,
  output logic            wb_en,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data
);
  logic [DEPTH-1:0]           vldPipe;
  logic [DEPTH-1:0]           entWen;
  logic [DEPTH-1:0]           entRdy;
  logic [DEPTH-1:0][RA_W-1:0] entRd;
  logic [DEPTH-1:0][XLEN-1:0] entData;

  logic                       issueOk;
  logic                       ldCapture;
  logic                       wbHit;
  logic [1:0][RA_W-1:0]       rsVec;
  logic [1:0]                 fwdEnVec;
  logic [1:0]                 pendVec;
  logic [1:0][XLEN-1:0]       fwdDataVec;

  assign issueOk   = issue_valid & ~flush & ~stall;
  assign ldCapture = vldPipe[LD_IDX] & ~entRdy[LD_IDX];

`ifdef FWD_SCOREBOARD_WB_BYPASS_EN
  assign wbHit = wb_en;
`else
  assign wbHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vldPipe <= '0;
      entWen  <= '0;
      entRdy  <= '0;
      entRd   <= '0;
      entData <= '0;
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      vldPipe[0] <= issueOk;
      entWen[0]  <= issue_wen;
      entRdy[0]  <= ~issue_is_load;
      entRd[0]   <= issue_rd;
      entData[0] <= issue_result;
      // Load data is captured as the pending load leaves LD_IDX, never bypassed combinationally.
      for (int i = DEPTH-1; i > 0; i--) begin
        vldPipe[i] <= vldPipe[i-1];
        entWen[i]  <= entWen[i-1];
        entRd[i]   <= entRd[i-1];
        entRdy[i]  <= (i-1 == LD_IDX && ldCapture) ? 1'b1 : entRdy[i-1];
        entData[i] <= (i-1 == LD_IDX && ldCapture) ? ld_data : entData[i-1];
      end
      wb_en   <= vldPipe[DEPTH-1] & entWen[DEPTH-1] & (entRd[DEPTH-1] != '0);
      wb_rd   <= entRd[DEPTH-1];
      wb_data <= (LD_IDX == DEPTH-1 && ldCapture) ? ld_data : entData[DEPTH-1];
    end
  end

  assign rsVec = {rs2, rs1};

  for (genvar q = 0; q < 2; q++) begin : gQuery
    fwdQuery #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH)) uQuery (
      .rs      (rsVec[q]),
      .entVld  (vldPipe),
      .entWen  (entWen),
      .entRdy  (entRdy),
      .entRd   (entRd),
      .entData (entData),
      .wbHit   (wbHit),
      .wbRd    (wb_rd),
      .wbData  (wb_data),
      .fwdEn   (fwdEnVec[q]),
      .fwdData (fwdDataVec[q]),
      .pend    (pendVec[q])
    );
  end

  assign fwd1_en   = fwdEnVec[0];
  assign fwd2_en   = fwdEnVec[1];
  assign fwd1_data = fwdDataVec[0];
  assign fwd2_data = fwdDataVec[1];
  assign stall     = |pendVec;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with an age-based in-flight model checked every cycle.
module tb_fwd_scoreboard;
  localparam int XLEN = 32, RA_W = 5, DEPTH = 2, LD_IDX = 0;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid, issue_wen, issue_is_load, flush;
  logic [RA_W-1:0] issue_rd, rs1, rs2, wb_rd;
  logic [XLEN-1:0] issue_result, ld_data, fwd1_data, fwd2_data, wb_data;
  logic            fwd1_en, fwd2_en, stall, wb_en;

  always #5 clk = ~clk;

  fwd_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .LD_IDX(LD_IDX)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_wen(issue_wen), .issue_is_load(issue_is_load), .issue_result(issue_result),
    .flush(flush), .ld_data(ld_data), .rs1(rs1), .rs2(rs2),
    .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  int nChecks = 0, nFails = 0;
  logic started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a list of in-flight instructions tagged with their age since issue.
  typedef struct {
    logic [RA_W-1:0] rd;
    logic            wen;
    logic            rdy;
    logic [XLEN-1:0] data;
    int              age;
  } rec_t;

  rec_t            q[$];
  rec_t            nq[$];
  rec_t            r;
  logic            mWbEn = 1'b0;
  logic [RA_W-1:0] mWbRd = '0;
  logic [XLEN-1:0] mWbData = '0;

  function automatic void mQuery(input logic [RA_W-1:0] rs, output logic en,
                                 output logic [XLEN-1:0] d, output logic pend);
    int best;
    best = 1 << 20;
    en = 1'b0; d = '0; pend = 1'b0;
`ifdef FWD_SCOREBOARD_WB_BYPASS_EN
    if (mWbEn && rs != 0 && mWbRd == rs) begin en = 1'b1; d = mWbData; end
`endif
    foreach (q[i]) begin
      if (rs != 0 && q[i].wen && q[i].rd == rs && q[i].age < best) begin
        best = q[i].age;
        en   = q[i].rdy;
        d    = q[i].rdy ? q[i].data : '0;
        pend = !q[i].rdy;
      end
    end
  endfunction

  logic            uE1, uE2, uP1, uP2, accept;
  logic [XLEN-1:0] uD1, uD2;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      mWbEn = 1'b0; mWbRd = '0; mWbData = '0;
    end else begin
      mQuery(rs1, uE1, uD1, uP1);
      mQuery(rs2, uE2, uD2, uP2);
      accept = issue_valid && !flush && !(uP1 || uP2);
      mWbEn = 1'b0;
      nq.delete();
      foreach (q[i]) begin
        r = q[i];
        if (r.age == LD_IDX && !r.rdy) begin r.rdy = 1'b1; r.data = ld_data; end
        if (r.age == DEPTH-1) begin
          mWbEn = r.wen && r.rd != 0; mWbRd = r.rd; mWbData = r.data;
        end else begin
          r.age++;
          nq.push_back(r);
        end
      end
      q = nq;
      if (accept) begin
        r.rd = issue_rd; r.wen = issue_wen; r.rdy = !issue_is_load;
        r.data = issue_result; r.age = 0;
        q.push_back(r);
      end
    end
  end

  logic            cE1, cE2, cP1, cP2;
  logic [XLEN-1:0] cD1, cD2;

  always @(negedge clk) begin
    if (started) begin
      mQuery(rs1, cE1, cD1, cP1);
      mQuery(rs2, cE2, cD2, cP2);
      check("cmp_stall", 32'(stall), 32'(cP1 | cP2));
      check("cmp_fwd1_en", 32'(fwd1_en), 32'(cE1));
      check("cmp_fwd2_en", 32'(fwd2_en), 32'(cE2));
      if (!cP1) check("cmp_fwd1_data", fwd1_data, cD1);
      if (!cP2) check("cmp_fwd2_data", fwd2_data, cD2);
      check("cmp_wb_en", 32'(wb_en), 32'(mWbEn));
      if (mWbEn) begin
        check("cmp_wb_rd", 32'(wb_rd), 32'(mWbRd));
        check("cmp_wb_data", wb_data, mWbData);
      end
    end
  end

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0; issue_wen = 1'b0; issue_is_load = 1'b0;
    issue_result = '0; flush = 1'b0; ld_data = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic iss(input logic [RA_W-1:0] rd, input logic [XLEN-1:0] res, input logic ld);
    issue_valid = 1'b1; issue_rd = rd; issue_wen = 1'b1; issue_is_load = ld; issue_result = res;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk); #1; started = 1'b1;
    nxt(); nxt();
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd1_en", 32'(fwd1_en), 0);
    check("rst_fwd1_data", fwd1_data, 0);
    check("rst_wb_en", 32'(wb_en), 0);
    reset = 1'b0;

    // back-to-back ALU forward
    nxt(); iss(5, 'h11, 0);
    nxt(); rs1 = 5; #1;
    check("alu_fwd1_en", 32'(fwd1_en), 1);
    check("alu_fwd1_data", fwd1_data, 'h11);
    check("alu_stall", 32'(stall), 0);

    // retire timing, plus wb-port bypass when enabled
    nxt(); iss(9, 'h55, 0);
    nxt();
    nxt(); #1;
    check("ret_wb_early", 32'(wb_en), 0);
    nxt(); rs1 = 9; #1;
    check("ret_wb_en", 32'(wb_en), 1);
    check("ret_wb_rd", 32'(wb_rd), 9);
    check("ret_wb_data", wb_data, 'h55);
`ifdef FWD_SCOREBOARD_WB_BYPASS_EN
    check("byp_fwd1_en", 32'(fwd1_en), 1);
    check("byp_fwd1_data", fwd1_data, 'h55);
`else
    check("nobyp_fwd1_en", 32'(fwd1_en), 0);
    check("nobyp_fwd1_data", fwd1_data, 0);
`endif
    nxt(); nxt(); nxt();

    // load-use: one stall cycle, the stalled issue is dropped
    nxt(); iss(7, 'hDEAD, 1);
    nxt(); rs2 = 7; iss(8, 'h88, 0); ld_data = 'hCAFE; #1;
    check("ld_stall", 32'(stall), 1);
    check("ld_fwd2_en_pend", 32'(fwd2_en), 0);
    nxt(); rs2 = 7; rs1 = 8; #1;
    check("ld_stall_clr", 32'(stall), 0);
    check("ld_fwd2_en", 32'(fwd2_en), 1);
    check("ld_fwd2_data", fwd2_data, 'hCAFE);
    check("ld_dropped_issue", 32'(fwd1_en), 0);

    // youngest wins
    nxt(); iss(3, 'hA, 0);
    nxt(); iss(3, 'hB, 0);
    nxt(); rs1 = 3; rs2 = 3; #1;
    check("pri_fwd1_data", fwd1_data, 'hB);
    check("pri_fwd2_data", fwd2_data, 'hB);

    // younger pending load shadows an older ready ALU result
    nxt(); iss(6, 'h66, 0);
    nxt(); iss(6, 'h0, 1);
    nxt(); rs1 = 6; ld_data = 'h77; #1;
    check("shadow_stall", 32'(stall), 1);
    check("shadow_fwd1_en", 32'(fwd1_en), 0);
    nxt(); rs1 = 6; #1;
    check("shadow_fwd1_data", fwd1_data, 'h77);

    // x0 and wen=0 never forward nor retire
    nxt(); iss(0, 'h12, 0);
    nxt(); iss(10, 'h34, 0); issue_wen = 1'b0; #1;
    check("x0_fwd1_en", 32'(fwd1_en), 0);
    nxt(); rs1 = 10; #1;
    check("wen0_fwd1_en", 32'(fwd1_en), 0);
    nxt(); #1;
    check("x0_wb_en", 32'(wb_en), 0);
    nxt(); #1;
    check("wen0_wb_en", 32'(wb_en), 0);

    // flushed issue disappears
    nxt(); iss(4, 'h44, 0); flush = 1'b1;
    nxt(); rs1 = 4; #1;
    check("flush_fwd1_en", 32'(fwd1_en), 0);
    check("flush_fwd1_data", fwd1_data, 0);
    nxt(); nxt(); #1;
    check("flush_wb_en", 32'(wb_en), 0);

    // flush during stall: bubble inserted, shift continues
    nxt(); iss(2, 'h0, 1);
    nxt(); rs1 = 2; iss(11, 'hBB, 0); flush = 1'b1; ld_data = 'h2222; #1;
    check("fs_stall", 32'(stall), 1);
    nxt(); rs1 = 11; rs2 = 2; #1;
    check("fs_fwd1_en", 32'(fwd1_en), 0);
    check("fs_fwd2_data", fwd2_data, 'h2222);

    // reset mid-flight
    nxt(); iss(12, 'h1, 0);
    nxt(); iss(13, 'h2, 0);
    nxt(); iss(14, 'h0, 1);
    nxt(); rs1 = 14; reset = 1'b1; #1;
    check("mid_pre_stall", 32'(stall), 1);
    nxt(); rs1 = 14; #1;
    check("mid_rst_stall", 32'(stall), 0);
    check("mid_rst_wb_en", 32'(wb_en), 0);
    reset = 1'b0;
    nxt(); rs1 = 13; #1;
    check("mid_fwd1_en", 32'(fwd1_en), 0);
    check("mid_wb_en0", 32'(wb_en), 0);
    nxt(); #1;
    check("mid_wb_en1", 32'(wb_en), 0);
    nxt(); #1;
    check("mid_wb_en2", 32'(wb_en), 0);
    nxt(); nxt();

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
